load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 164 ++++++++++++++++
 tb/tb_load_store_unit.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module   : load_store_unit
//  Function : RV32I load/store sequencer. Aligns, lane-replicates and strobes
//             stores; selects and extends load data. The build macro
//             LSU_MISALIGN_TRAP_EN turns misaligned H/W accesses into faults
//             instead of silently aligning them.
//  Revision : 1.0  initial release
// ============================================================================
module load_store_unit #(
    parameter int ADDR_W = 32
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_we,
    input  logic [2:0]        i_funct3,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [31:0]       i_wdata,
    output logic              o_rsp_valid,
    output logic [31:0]       o_rdata,
    output logic              o_misaligned,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [31:0]       o_mem_wd,
    output logic [3:0]        o_mem_wen,
    output logic              o_mem_ren,
    input  logic [31:0]       i_mem_rd
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_WAIT   = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t              state_q;
    logic                we_q;
    logic [2:0]          funct3_q;
    logic [1:0]          lane_q;
    logic                rsp_valid_q;
    logic                misaligned_q;
    logic [31:0]         rdata_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [31:0]         mem_wd_q;
    logic [3:0]          mem_wen_q;
    logic                mem_ren_q;

    logic                is_half;
    logic                is_word;
    logic                fault_d;
    logic [1:0]          lane_d;
    logic [3:0]          wen_d;
    logic [31:0]         wd_d;
    logic [31:0]         rdata_d;
    logic [7:0]          byte_sel;
    logic [15:0]         half_sel;

    // funct3[1] set covers both 010 and the reserved 011 code, both taken as word
    always_comb begin
        is_half = (i_funct3[1:0] == 2'b01);
        is_word = i_funct3[1];
`ifdef LSU_MISALIGN_TRAP_EN
        lane_d  = i_addr[1:0];
        fault_d = (is_half && i_addr[0]) || (is_word && (i_addr[1:0] != 2'b00));
`else
        fault_d = 1'b0;
        lane_d  = is_word ? 2'b00 : (is_half ? {i_addr[1], 1'b0} : i_addr[1:0]);
`endif
        if (is_word) begin
            wen_d = 4'b1111;
            wd_d  = i_wdata;
        end else if (is_half) begin
            wen_d = 4'b0011 << lane_d;
            wd_d  = {2{i_wdata[15:0]}};
        end else begin
            wen_d = 4'b0001 << lane_d;
            wd_d  = {4{i_wdata[7:0]}};
        end
    end

    always_comb begin
        byte_sel = i_mem_rd[{lane_q, 3'b000} +: 8];
        half_sel = lane_q[1] ? i_mem_rd[31:16] : i_mem_rd[15:0];
        case (funct3_q[1:0])
            2'b00:   rdata_d = {{24{byte_sel[7] & ~funct3_q[2]}}, byte_sel};
            2'b01:   rdata_d = {{16{half_sel[15] & ~funct3_q[2]}}, half_sel};
            default: rdata_d = i_mem_rd;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= S_IDLE;
            we_q         <= 1'b0;
            funct3_q     <= 3'b000;
            lane_q       <= 2'b00;
            rsp_valid_q  <= 1'b0;
            misaligned_q <= 1'b0;
            rdata_q      <= '0;
            mem_addr_q   <= '0;
            mem_wd_q     <= '0;
            mem_wen_q    <= 4'b0000;
            mem_ren_q    <= 1'b0;
        end else begin
            // Strobes and the completion pulse are single-cycle by default
            mem_wen_q    <= 4'b0000;
            mem_ren_q    <= 1'b0;
            rsp_valid_q  <= 1'b0;
            misaligned_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (i_req_valid) begin
                        we_q       <= i_we;
                        funct3_q   <= i_funct3;
                        lane_q     <= lane_d;
                        mem_addr_q <= {i_addr[ADDR_W-1:2], 2'b00};
                        if (fault_d) begin
                            state_q      <= S_RESP;
                            rsp_valid_q  <= 1'b1;
                            misaligned_q <= 1'b1;
                        end else begin
                            state_q <= S_ACCESS;
                            if (i_we) begin
                                mem_wen_q <= wen_d;
                                mem_wd_q  <= wd_d;
                            end else begin
                                mem_ren_q <= 1'b1;
                            end
                        end
                    end
                end
                S_ACCESS: begin
                    if (we_q) begin
                        state_q     <= S_RESP;
                        rsp_valid_q <= 1'b1;
                    end else begin
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    rdata_q     <= rdata_d;
                    rsp_valid_q <= 1'b1;
                    state_q     <= S_RESP;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign o_req_ready  = (state_q == S_IDLE);
    assign o_rsp_valid  = rsp_valid_q;
    assign o_rdata      = rdata_q;
    assign o_misaligned = misaligned_q;
    assign o_mem_addr   = mem_addr_q;
    assign o_mem_wd     = mem_wd_q;
    assign o_mem_wen    = mem_wen_q;
    assign o_mem_ren    = mem_ren_q;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_load_store_unit
//  Function : Directed self-checking bench for load_store_unit with a small
//             word-addressed memory model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_load_store_unit;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rsp_valid;
    logic [31:0] rdata;
    logic        misaligned;
    logic [31:0] mem_addr;
    logic [31:0] mem_wd;
    logic [3:0]  mem_wen;
    logic        mem_ren;
    logic [31:0] mem_rd;

    logic        preload;
    logic [31:0] mem [0:63];

    int n_checks;
    int n_fail;

    load_store_unit #(.ADDR_W(32)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_req_valid  (req_valid),
        .o_req_ready  (req_ready),
        .i_we         (we),
        .i_funct3     (funct3),
        .i_addr       (addr),
        .i_wdata      (wdata),
        .o_rsp_valid  (rsp_valid),
        .o_rdata      (rdata),
        .o_misaligned (misaligned),
        .o_mem_addr   (mem_addr),
        .o_mem_wd     (mem_wd),
        .o_mem_wen    (mem_wen),
        .o_mem_ren    (mem_ren),
        .i_mem_rd     (mem_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (preload) begin
            mem[4] <= 32'h8070F0A5;
            mem[5] <= 32'h00005678;
            mem[6] <= 32'h00000000;
            mem[7] <= 32'h00000000;
            mem[8] <= 32'hCAFEBABE;
            mem_rd <= 32'h0;
        end else begin
            if (mem_ren) mem_rd <= mem[mem_addr[7:2]];
            for (int n = 0; n < 4; n++)
                if (mem_wen[n]) mem[mem_addr[7:2]][8*n +: 8] <= mem_wd[8*n +: 8];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Called with the DUT idle; returns one cycle after the completion pulse.
    task automatic lsu_op(input string tag, input logic op_we, input logic [2:0] op_f3,
                          input logic [31:0] op_addr, input logic [31:0] op_wdata,
                          input int exp_lat, input logic [3:0] exp_wen, input logic exp_ren,
                          input logic [31:0] exp_maddr, input logic [31:0] exp_wd,
                          input logic exp_mis, input logic [31:0] exp_rdata);
        int          lat;
        int          n_wen;
        int          n_ren;
        logic [3:0]  seen_wen;
        logic [31:0] seen_addr;
        logic [31:0] seen_wd;
        logic        seen_mis;
        lat = 0; n_wen = 0; n_ren = 0;
        seen_wen = 4'b0; seen_addr = 32'h0; seen_wd = 32'h0; seen_mis = 1'b0;
        chk({tag, "/ready"}, {31'b0, req_ready}, 32'd1);
        req_valid = 1'b1; we = op_we; funct3 = op_f3; addr = op_addr; wdata = op_wdata;
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            if (mem_wen != 4'b0) begin
                n_wen++; seen_wen = mem_wen; seen_wd = mem_wd; seen_addr = mem_addr;
            end
            if (mem_ren) begin
                n_ren++; seen_addr = mem_addr;
            end
            if (rsp_valid) begin
                lat = c; seen_mis = misaligned;
                break;
            end
            @(posedge clk); #1;
        end
        chk({tag, "/latency"}, lat, exp_lat);
        chk({tag, "/wen_cycles"}, n_wen, (exp_wen != 4'b0) ? 1 : 0);
        chk({tag, "/ren_cycles"}, n_ren, exp_ren ? 1 : 0);
        chk({tag, "/wen"}, {28'b0, seen_wen}, {28'b0, exp_wen});
        if (exp_wen != 4'b0 || exp_ren) chk({tag, "/mem_addr"}, seen_addr, exp_maddr);
        if (exp_wen != 4'b0) chk({tag, "/mem_wd"}, seen_wd, exp_wd);
        chk({tag, "/misaligned"}, {31'b0, seen_mis}, {31'b0, exp_mis});
        chk({tag, "/rdata"}, rdata, exp_rdata);
        @(posedge clk); #1;
    endtask

    initial begin
        int acc;
        int rsps;
        int busy;
        n_checks = 0; n_fail = 0;
        rst_n = 1'b0; preload = 1'b1;
        req_valid = 1'b0; we = 1'b0; funct3 = 3'b000; addr = 32'h0; wdata = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst/rsp_valid",  {31'b0, rsp_valid},  32'd0);
        chk("rst/misaligned", {31'b0, misaligned}, 32'd0);
        chk("rst/wen",        {28'b0, mem_wen},    32'd0);
        chk("rst/ren",        {31'b0, mem_ren},    32'd0);
        chk("rst/rdata",      rdata,               32'd0);
        chk("rst/mem_addr",   mem_addr,            32'd0);
        chk("rst/mem_wd",     mem_wd,              32'd0);
        chk("rst/ready",      {31'b0, req_ready},  32'd1);
        preload = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        //      tag      we   f3      addr          wdata         lat wen      ren   maddr         wd            mis   rdata
        lsu_op("LB10",   0, 3'b000, 32'h10, 32'h0,        3, 4'b0000, 1'b1, 32'h10, 32'h0,        1'b0, 32'hFFFFFFA5);
        lsu_op("LBU10",  0, 3'b100, 32'h10, 32'h0,        3, 4'b0000, 1'b1, 32'h10, 32'h0,        1'b0, 32'h000000A5);
        lsu_op("LH12",   0, 3'b001, 32'h12, 32'h0,        3, 4'b0000, 1'b1, 32'h10, 32'h0,        1'b0, 32'hFFFF8070);
        lsu_op("LHU12",  0, 3'b101, 32'h12, 32'h0,        3, 4'b0000, 1'b1, 32'h10, 32'h0,        1'b0, 32'h00008070);
        lsu_op("LW10",   0, 3'b010, 32'h10, 32'h0,        3, 4'b0000, 1'b1, 32'h10, 32'h0,        1'b0, 32'h8070F0A5);
        lsu_op("SB13",   1, 3'b000, 32'h13, 32'h000000A5, 2, 4'b1000, 1'b0, 32'h10, 32'hA5A5A5A5, 1'b0, 32'h8070F0A5);
        lsu_op("LW10b",  0, 3'b010, 32'h10, 32'h0,        3, 4'b0000, 1'b1, 32'h10, 32'h0,        1'b0, 32'hA570F0A5);
        lsu_op("SH16",   1, 3'b001, 32'h16, 32'hABCD1234, 2, 4'b1100, 1'b0, 32'h14, 32'h12341234, 1'b0, 32'hA570F0A5);
        lsu_op("LW14",   0, 3'b010, 32'h14, 32'h0,        3, 4'b0000, 1'b1, 32'h14, 32'h0,        1'b0, 32'h12345678);
`ifdef LSU_MISALIGN_TRAP_EN
        lsu_op("LW21",   0, 3'b010, 32'h21, 32'h0,        1, 4'b0000, 1'b0, 32'h20, 32'h0,        1'b1, 32'h12345678);
`else
        lsu_op("LW21",   0, 3'b010, 32'h21, 32'h0,        3, 4'b0000, 1'b1, 32'h20, 32'h0,        1'b0, 32'hCAFEBABE);
`endif
        lsu_op("LB21",   0, 3'b000, 32'h21, 32'h0,        3, 4'b0000, 1'b1, 32'h20, 32'h0,        1'b0, 32'hFFFFFFBA);
        lsu_op("SW18",   1, 3'b010, 32'h18, 32'hDEADBEEF, 2, 4'b1111, 1'b0, 32'h18, 32'hDEADBEEF, 1'b0, 32'hFFFFFFBA);
        lsu_op("SBU1A",  1, 3'b100, 32'h1A, 32'h00000077, 2, 4'b0100, 1'b0, 32'h18, 32'h77777777, 1'b0, 32'hFFFFFFBA);
        lsu_op("L011",   0, 3'b011, 32'h18, 32'h0,        3, 4'b0000, 1'b1, 32'h18, 32'h0,        1'b0, 32'hDE77BEEF);
        lsu_op("LHU1A",  0, 3'b101, 32'h1A, 32'h0,        3, 4'b0000, 1'b1, 32'h18, 32'h0,        1'b0, 32'h0000DE77);

        // Continuous request stream: one accept per 4-cycle load
        acc = 0; rsps = 0; busy = 0;
        req_valid = 1'b1; we = 1'b0; funct3 = 3'b010; addr = 32'h10; wdata = 32'h0;
        for (int i = 0; i < 12; i++) begin
            if (req_ready) acc++;
            else busy++;
            if (rsp_valid) rsps++;
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        chk("stream/accepts",   acc,   32'd3);
        chk("stream/responses", rsps,  32'd3);
        chk("stream/not_ready", busy,  32'd9);
        chk("stream/rdata",     rdata, 32'hA570F0A5);
        @(posedge clk); #1;

        // Reset in the middle of a word store
        req_valid = 1'b1; we = 1'b1; funct3 = 3'b010; addr = 32'h1C; wdata = 32'hDEADBEEF;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("abort/wen_before", {28'b0, mem_wen}, 32'h0000000F);
        #2 rst_n = 1'b0;
        #1;
        chk("abort/wen_after",  {28'b0, mem_wen},   32'd0);
        chk("abort/rsp_valid",  {31'b0, rsp_valid}, 32'd0);
        chk("abort/mem_addr",   mem_addr,           32'd0);
        chk("abort/rdata",      rdata,              32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort/ready_release", {31'b0, req_ready}, 32'd1);
        lsu_op("LW1C",   0, 3'b010, 32'h1C, 32'h0,        3, 4'b0000, 1'b1, 32'h1C, 32'h0,        1'b0, 32'h00000000);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
